wb_regfile: RTL

Writeback-stage consumer of the MEM/WB pipeline buffer outputs. It takes the buffered word result, loaded byte, destination-register index and 4-bit WB control, and commits the selected value into a 16-entry register file. It provides two synchronous read ports to the decode stage with same-edge write bypass, a one-cycle writeback forwarding record for the EX forwarding unit, and a committed-write counter for debug.

---
 rtl/wb_regfile.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-stage register file.
// Commits the MEM/WB result (word, extended byte or high-byte insert) into a
// register array with R0 hardwired to zero. Two registered read ports bypass a
// same-edge commit, a one-cycle forwarding record feeds the EX forwarding unit,
// and an 8-bit counter tracks committed writes for debug.
module wb_regfile #(
  parameter int S = 15,
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [S:0]   InWord,
  input  logic [7:0]   InByte,
  input  logic [3:0]   InCtrl,
  input  logic [N:0]   InDest,
  input  logic [N:0]   RdAddrA,
  input  logic [N:0]   RdAddrB,
  output logic [S:0]   RdDataA,
  output logic [S:0]   RdDataB,
  output logic         FwdValid,
  output logic [N:0]   FwdReg,
  output logic [S:0]   FwdData,
  output logic [7:0]   WrCount
);

  localparam int NREG = 2 ** (N + 1);

  logic [S:0] mem_r [NREG];
  logic [S:0] cur_s;
  logic [S:0] wv_s;
  logic [S:0] rd_a_s;
  logic [S:0] rd_b_s;
  logic       commit_s;

  // Commit qualifier: RegWrite set and destination is not the hardwired R0.
  always_comb begin
    commit_s = 1'b0;
    if (InCtrl[0] && (InDest != {(N+1){1'b0}})) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  assign cur_s = mem_r[InDest];

  // Write value selection: word, sign/zero-extended byte, or high-byte insert
  // merged with the currently stored low byte.
  always_comb begin
    wv_s = {(S+1){1'b0}};
    case ({InCtrl[1], InCtrl[3]})
      2'b00, 2'b01: begin
        wv_s = InWord;
      end
      2'b10: begin
        if (InCtrl[2]) begin
          wv_s = {{(S-7){InByte[7]}}, InByte};
        end else begin
          wv_s = {{(S-7){1'b0}}, InByte};
        end
      end
      2'b11: begin
        wv_s = cur_s;
        wv_s[15:8] = InByte;
      end
      default: begin
        wv_s = {(S+1){1'b0}};
      end
    endcase
  end

  // Read port A next value: zero for R0, bypass a same-edge commit, else array.
  always_comb begin
    rd_a_s = {(S+1){1'b0}};
    if (RdAddrA == {(N+1){1'b0}}) begin
      rd_a_s = {(S+1){1'b0}};
    end else if (commit_s && (RdAddrA == InDest)) begin
      rd_a_s = wv_s;
    end else begin
      rd_a_s = mem_r[RdAddrA];
    end
  end

  // Read port B next value: same rules as port A.
  always_comb begin
    rd_b_s = {(S+1){1'b0}};
    if (RdAddrB == {(N+1){1'b0}}) begin
      rd_b_s = {(S+1){1'b0}};
    end else if (commit_s && (RdAddrB == InDest)) begin
      rd_b_s = wv_s;
    end else begin
      rd_b_s = mem_r[RdAddrB];
    end
  end

  // Register array update; reset clears every entry and R0 is never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {(S+1){1'b0}};
      end
    end else if (commit_s) begin
      mem_r[InDest] <= wv_s;
    end else begin
      mem_r[InDest] <= mem_r[InDest];
    end
  end

  // Registered read ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      RdDataA <= {(S+1){1'b0}};
      RdDataB <= {(S+1){1'b0}};
    end else begin
      RdDataA <= rd_a_s;
      RdDataB <= rd_b_s;
    end
  end

  // Forwarding record: valid pulses for one cycle, payload holds between commits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      FwdValid <= 1'b0;
      FwdReg   <= {(N+1){1'b0}};
      FwdData  <= {(S+1){1'b0}};
    end else if (commit_s) begin
      FwdValid <= 1'b1;
      FwdReg   <= InDest;
      FwdData  <= wv_s;
    end else begin
      FwdValid <= 1'b0;
    end
  end

  // Committed-write counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      WrCount <= 8'h00;
    end else if (commit_s) begin
      WrCount <= WrCount + 8'h01;
    end else begin
      WrCount <= WrCount;
    end
  end

endmodule
